// File: rtl/multi_lane_serial_popcount_pkg.sv
// Shared types and helpers for the multi-lane bit-serial ones counter.
// Optional abort support in the top is enabled by SERIAL_POPCOUNT_ABORT_EN.
package serial_popcount_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_BIPOLAR  = 1'b1;

  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/multi_lane_serial_popcount_lane.sv
// One lane: ones counter with clear/increment and unsigned/bipolar result conversion.
// The result reflects the count including the bit accepted this cycle.
module serial_popcount_lane
  import serial_popcount_pkg::*;
#(
  parameter int FRAME_LEN = 6,
  parameter int CNT_W     = cnt_width(FRAME_LEN),
  parameter int OUT_W     = CNT_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  input  logic             mode_i,
  output logic [OUT_W-1:0] sum_o
);

  logic [CNT_W-1:0] ones_q;
  logic [CNT_W-1:0] ones_d;
  logic [CNT_W-1:0] base_s;
  logic             inc_s;

  // next ones count and its signed/unsigned view
  always_comb begin
    inc_s = en_i & bit_i;
    if (clr_i) begin
      base_s = {CNT_W{1'b0}};
    end else begin
      base_s = ones_q;
    end
    ones_d = base_s + {{(CNT_W-1){1'b0}}, inc_s};
    // 2*ones - FRAME_LEN stays within OUT_W because ones <= FRAME_LEN
    if (mode_i == MODE_BIPOLAR) begin
      sum_o = {ones_d, 1'b0} - OUT_W'(FRAME_LEN);
    end else begin
      sum_o = {1'b0, ones_d};
    end
  end

  // ones counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= {CNT_W{1'b0}};
    end else begin
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/multi_lane_serial_popcount.sv
// Multi-lane framed serial popcount: shared IDLE/RUN FSM and bit counter, per-lane counters.
// Define SERIAL_POPCOUNT_ABORT_EN to add the abort input that discards a frame in progress.
module multi_lane_serial_popcount
  import serial_popcount_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int FRAME_LEN = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   bit_valid,
  input  logic [NUM_LANES-1:0]                   serial_in,
  input  logic                                   mode,
`ifdef SERIAL_POPCOUNT_ABORT_EN
  input  logic                                   abort,
`endif
  output logic                                   busy,
  output logic                                   valid,
  output logic [NUM_LANES*(cnt_width(FRAME_LEN)+1)-1:0] sum_out
);

  localparam int CNT_W = cnt_width(FRAME_LEN);
  localparam int OUT_W = CNT_W + 1;

  state_e                     state_q;
  logic [CNT_W-1:0]           bit_cnt_q;
  logic                       mode_q;
  logic                       busy_q;
  logic                       valid_q;
  logic [NUM_LANES*OUT_W-1:0] sum_q;
  logic [NUM_LANES*OUT_W-1:0] lane_sum_s;

  logic abort_s;
  logic start_acc_s;
  logic abort_run_s;
  logic accept_s;
  logic last_s;
  logic clr_s;

`ifdef SERIAL_POPCOUNT_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // frame control decode
  always_comb begin
    start_acc_s = (state_q == IDLE) && start && !abort_s;
    abort_run_s = (state_q == RUN) && abort_s;
    accept_s    = bit_valid && (((state_q == RUN) && !abort_s) || start_acc_s);
    last_s      = (state_q == RUN) && !abort_s && bit_valid &&
                  (bit_cnt_q == CNT_W'(FRAME_LEN - 1));
    clr_s       = start_acc_s || abort_run_s;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    serial_popcount_lane #(
      .FRAME_LEN (FRAME_LEN),
      .CNT_W     (CNT_W),
      .OUT_W     (OUT_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (clr_s),
      .en_i   (accept_s),
      .bit_i  (serial_in[g]),
      .mode_i (mode_q),
      .sum_o  (lane_sum_s[g*OUT_W +: OUT_W])
    );
  end

  // FSM, bit counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= {CNT_W{1'b0}};
      mode_q    <= MODE_UNSIGNED;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      sum_q     <= {(NUM_LANES*OUT_W){1'b0}};
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_acc_s) begin
            mode_q    <= mode;
            bit_cnt_q <= {{(CNT_W-1){1'b0}}, bit_valid};
            state_q   <= RUN;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (abort_s) begin
            bit_cnt_q <= {CNT_W{1'b0}};
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end else if (last_s) begin
            sum_q     <= lane_sum_s;
            valid_q   <= 1'b1;
            bit_cnt_q <= {CNT_W{1'b0}};
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end else if (bit_valid) begin
            bit_cnt_q <= bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign sum_out = sum_q;

endmodule

// File: tb/tb_multi_lane_serial_popcount.sv
// Directed self-checking bench for multi_lane_serial_popcount (4 lanes, 6-bit frames).
module tb_multi_lane_serial_popcount;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        bit_valid;
  logic [3:0]  serial_in;
  logic        mode;
`ifdef SERIAL_POPCOUNT_ABORT_EN
  logic        abort;
`endif
  logic        busy;
  logic        valid;
  logic [15:0] sum_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_lane_serial_popcount dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .serial_in (serial_in),
    .mode      (mode),
`ifdef SERIAL_POPCOUNT_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .valid     (valid),
    .sum_out   (sum_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame (word t = lane bits of frame bit t), optionally with a gap after bit gap_at.
  // mode is inverted after the start cycle to show it is ignored during RUN.
  task automatic frame(input string tag, input logic m, input logic [23:0] w,
                       input int gap_at, input int gap_len, input logic [15:0] exp);
    for (int t = 0; t < 6; t++) begin
      start     = (t == 0);
      bit_valid = 1'b1;
      serial_in = w[t*4 +: 4];
      mode      = (t == 0) ? m : ~m;
      tick();
      start     = 1'b0;
      bit_valid = 1'b0;
      if (t < 5) begin
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_novalid"}, 32'(valid), 32'd0);
      end
      if (t == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          start     = 1'b1;
          serial_in = 4'hF;
          tick();
          start = 1'b0;
          check_eq({tag, "_gap_busy"}, 32'(busy), 32'd1);
          check_eq({tag, "_gap_novalid"}, 32'(valid), 32'd0);
        end
      end
    end
    check_eq({tag, "_valid"}, 32'(valid), 32'd1);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    check_eq({tag, "_sum"}, 32'(sum_out), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; serial_in = 4'h0; mode = 1'b0;
`ifdef SERIAL_POPCOUNT_ABORT_EN
    abort = 1'b0;
`endif
    tick(); tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_sum", 32'(sum_out), 32'd0);
    rst = 1'b0;

    // bits without start are ignored in IDLE
    bit_valid = 1'b1; serial_in = 4'hF;
    tick(); tick();
    check_eq("idle_ignore_busy", 32'(busy), 32'd0);
    check_eq("idle_ignore_valid", 32'(valid), 32'd0);
    bit_valid = 1'b0; serial_in = 4'h0;

    frame("s1", 1'b0, 24'h110101, -1, 0, 16'h0004);
    tick();
    check_eq("s1_pulse_one", 32'(valid), 32'd0);
    check_eq("s1_hold", 32'(sum_out), 32'h0004);

    frame("s2", 1'b1, 24'h551D9D, -1, 0, 16'h02A6);
    // back-to-back: start in the valid cycle, second valid exactly 6 cycles later
    frame("s3", 1'b0, 24'h111111, -1, 0, 16'h0006);
    frame("all1_bip", 1'b1, 24'hFFFFFF, -1, 0, 16'h6666);
    frame("all0_bip", 1'b1, 24'h000000, -1, 0, 16'hAAAA);
    frame("all1_uns", 1'b0, 24'hFFFFFF, -1, 0, 16'h6666);

    frame("s4", 1'b0, 24'h110101, 2, 3, 16'h0004);
    tick();

    // reset in the middle of a frame after 3 bits
    for (int t = 0; t < 3; t++) begin
      start = (t == 0); bit_valid = 1'b1; serial_in = 4'hF; mode = 1'b0;
      tick();
    end
    start = 1'b0; bit_valid = 1'b0;
    check_eq("s5_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("s5_busy", 32'(busy), 32'd0);
    check_eq("s5_sum", 32'(sum_out), 32'd0);
    check_eq("s5_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("s5_no_valid", 32'(valid), 32'd0);
    end
    frame("s5_after", 1'b0, 24'h111111, -1, 0, 16'h0006);
    tick();

`ifdef SERIAL_POPCOUNT_ABORT_EN
    // abort after four accepted bits, with a bit presented in the abort cycle
    for (int t = 0; t < 4; t++) begin
      start = (t == 0); bit_valid = 1'b1; serial_in = 4'hF; mode = 1'b0;
      tick();
    end
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0; bit_valid = 1'b0;
    check_eq("s6_busy", 32'(busy), 32'd0);
    check_eq("s6_valid", 32'(valid), 32'd0);
    check_eq("s6_sum_kept", 32'(sum_out), 32'h0006);
    tick();
    check_eq("s6_valid_later", 32'(valid), 32'd0);
    // start together with abort in IDLE is not accepted
    start = 1'b1; abort = 1'b1; bit_valid = 1'b1; serial_in = 4'hF;
    tick();
    start = 1'b0; abort = 1'b0; bit_valid = 1'b0;
    check_eq("s6_start_blocked", 32'(busy), 32'd0);
    frame("s6_next", 1'b0, 24'h110101, -1, 0, 16'h0004);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
